serial_adder: RTL and testbench
===============================

SERIAL_ADDER -- requirements
Module: serial_adder

Interface
REQ-001 The block SHALL have parameter WIDTH, default 8, meaning operand width in bits.
REQ-002 The block SHALL have parameter SLICE, default 1, meaning bits added per clock cycle.
REQ-003 The block SHALL have port clk, input, 1, meaning the single clock, with all state updated on its rising edge.
REQ-004 The block SHALL have port rst_n, input, 1, meaning asynchronous active-low reset.
REQ-005 The block SHALL have port in_valid, input, 1, meaning the operands are offered.
REQ-006 The block SHALL have port in_ready, output, 1, meaning the block can accept operands.
REQ-007 The block SHALL have ports a and b, input, WIDTH each, meaning the operands.
REQ-008 The block SHALL have port cin, input, 1, meaning carry-in.
REQ-009 The block SHALL have port out_valid, output, 1, meaning the result is presented.
REQ-010 The block SHALL have port out_ready, input, 1, meaning the consumer accepts the result.
REQ-011 The block SHALL have port sum, output, WIDTH, meaning the result.
REQ-012 The block SHALL have port cout, output, 1, meaning carry-out of the MSB.
REQ-013 The block SHALL have port busy, output, 1, meaning the state is not IDLE.

Function
REQ-014 An elaboration error SHALL occur if SLICE is less than 1 or WIDTH is not a multiple of SLICE; N = WIDTH/SLICE.
REQ-015 The FSM SHALL have exactly the states IDLE, RUN and DONE.
REQ-016 in_ready SHALL be 1 only in IDLE.
REQ-017 A transfer SHALL occur when in_valid and in_ready are both 1; on that edge a, b and cin are captured, the slice counter is cleared, and the FSM goes IDLE->RUN.
REQ-018 Inputs SHALL be ignored outside IDLE, and captured operands SHALL be immune to later input changes.
REQ-019 RUN cycle k (k = 0..N-1) SHALL add slice k of a, slice k of b and the running carry, store the SLICE result bits, and update the carry.
REQ-020 After RUN cycle N-1 the FSM SHALL go RUN->DONE, loading sum and cout on the same edge.
REQ-021 Latency SHALL be: acceptance at edge t gives out_valid=1 after edge t+N.
REQ-022 In DONE, out_valid SHALL be 1, and sum and cout SHALL be stable until the result is taken.
REQ-023 The FSM SHALL go DONE->IDLE on the edge where out_ready=1; out_ready outside DONE SHALL have no effect.
REQ-024 Throughput SHALL be one operation per N+2 cycles when out_ready is held high.
REQ-025 sum and cout SHALL keep the previous result from IDLE through RUN.
REQ-026 Arithmetic SHALL be unsigned modulo 2^WIDTH, with cout = bit WIDTH of a+b+cin.
REQ-027 When SLICE=WIDTH, RUN SHALL last exactly one cycle.

Reset
REQ-028 While rst_n=0, the state SHALL be IDLE and sum=0, cout=0, out_valid=0, busy=0, in_ready=1.
REQ-029 The counter and carry SHALL be cleared asynchronously by reset.
REQ-030 Reset asserted in RUN or DONE SHALL abort the operation with no result delivered.
REQ-031 Operation SHALL resume on the first rising edge after rst_n deasserts.

Configuration
REQ-032 With SERIAL_ADDER_OVF_EN defined, the block SHALL have output port ovf, 1 bit, registered with sum, equal to carry-into-MSB XOR cout (signed two's-complement overflow), and reset to 0.
REQ-033 With SERIAL_ADDER_OVF_EN undefined, the ovf port and its logic SHALL be absent.

Structure
REQ-034 Package serial_adder_pkg SHALL hold the state enum (IDLE, RUN, DONE) and a function computing counter width from N.
REQ-035 Sub-module add_slice (SLICE-bit combinational adder with carry in/out) SHALL be instantiated once per block.

Verification
REQ-036 Bench SHALL cover: WIDTH=8, SLICE=1, a=0x35, b=0x4A, cin=0 -> out_valid 8 cycles after accept, sum=0x7F, cout=0.
REQ-037 Bench SHALL cover: WIDTH=8, SLICE=2, a=0xFF, b=0x00, cin=1 -> after 4 cycles sum=0x00, cout=1 (full carry ripple across slices).
REQ-038 Bench SHALL cover: out_ready held 0 for 5 cycles in DONE -> sum and cout stable, in_ready=0, new in_valid ignored; out_ready=1 -> IDLE on the next edge.
REQ-039 Bench SHALL cover: rst_n pulsed low in RUN cycle 3 -> outputs 0 immediately, IDLE, no out_valid afterwards.
REQ-040 Bench SHALL cover: operands changed during RUN -> result uses the captured values.
REQ-041 Bench SHALL cover, with SERIAL_ADDER_OVF_EN defined: a=0x7F, b=0x01 -> sum=0x80, ovf=1, cout=0; and a=0x80, b=0x80 -> sum=0x00, ovf=1, cout=1.

Source files
------------

// File: rtl/serial_adder_pkg.sv
`default_nettype none
// ============================================================================
// Module  : serial_adder_pkg
// Brief   : Shared types and helpers for the serial adder.
// Rev     : 1.0  initial release
// ============================================================================
package serial_adder_pkg;

   // Operation phases of the serial adder
   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

   // Bits needed to count slices 0..n-1 (never less than one bit)
   function automatic int cnt_width(input int n);
      return (n <= 2) ? 1 : $clog2(n);
   endfunction

endpackage
`default_nettype wire

// File: rtl/serial_adder_add_slice.sv
`default_nettype none
// ============================================================================
// Module  : add_slice
// Brief   : SLICE-bit combinational adder with carry in and carry out.
// Rev     : 1.0  initial release
// ============================================================================
module add_slice #(
   parameter int SLICE = 1
) (
   input  logic [SLICE-1:0] a,
   input  logic [SLICE-1:0] b,
   input  logic             ci,
   output logic [SLICE-1:0] s,
   output logic             co
);

   // One-bit-wider add so the carry out falls out of the top bit
   assign {co, s} = {1'b0, a} + {1'b0, b} + {{SLICE{1'b0}}, ci};

endmodule
`default_nettype wire

// File: rtl/serial_adder.sv
`default_nettype none
// ============================================================================
// Module  : serial_adder
// Brief   : Multi-cycle adder that sums two WIDTH-bit operands SLICE bits per
//           clock, with valid/ready handshakes on both sides.
//           Optional macro SERIAL_ADDER_OVF_EN adds a signed-overflow output.
// Rev     : 1.0  initial release
// ============================================================================
module serial_adder
   import serial_adder_pkg::*;
#(
   parameter int WIDTH = 8,
   parameter int SLICE = 1
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             cin,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] sum,
   output logic             cout,
   output logic             busy
`ifdef SERIAL_ADDER_OVF_EN
   ,
   output logic             ovf
`endif
);

   localparam int            N    = (SLICE >= 1) ? (WIDTH / SLICE) : 1;
   localparam int            CW   = cnt_width(N);
   localparam logic [CW-1:0] LAST = CW'(N - 1);

   // Reject slice widths that do not tile the operand exactly
   generate
      if ((SLICE < 1) || ((WIDTH % ((SLICE < 1) ? 1 : SLICE)) != 0)) begin : g_bad_param
         $error("serial_adder: SLICE must be >= 1 and divide WIDTH");
      end
   endgenerate

   state_t            r_state;
   logic [WIDTH-1:0]  r_a;
   logic [WIDTH-1:0]  r_b;
   logic [WIDTH-1:0]  r_acc;
   logic              r_carry;
   logic [CW-1:0]     r_cnt;

   logic [SLICE-1:0]  w_s;
   logic              w_co;
   logic [WIDTH-1:0]  w_acc_next;

   // Captured operands shift right each RUN cycle, so the current slice is
   // always in the low bits; the adder only ever looks there.
   add_slice #(
      .SLICE (SLICE)
   ) u_add_slice (
      .a  (r_a[SLICE-1:0]),
      .b  (r_b[SLICE-1:0]),
      .ci (r_carry),
      .s  (w_s),
      .co (w_co)
   );

   // Result slices enter at the top; after N cycles slice 0 sits at the bottom
   generate
      if (SLICE == WIDTH) begin : g_one_slice
         assign w_acc_next = w_s;
      end else begin : g_multi_slice
         assign w_acc_next = {w_s, r_acc[WIDTH-1:SLICE]};
      end
   endgenerate

`ifdef SERIAL_ADDER_OVF_EN
   logic w_ovf;
   // a^b^s at the MSB recovers the carry into the MSB; XOR with cout flags overflow
   assign w_ovf = r_a[SLICE-1] ^ r_b[SLICE-1] ^ w_s[SLICE-1] ^ w_co;
`endif

   // Control FSM, operand/accumulator datapath and registered outputs
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state   <= IDLE;
         r_a       <= '0;
         r_b       <= '0;
         r_acc     <= '0;
         r_carry   <= 1'b0;
         r_cnt     <= '0;
         sum       <= '0;
         cout      <= 1'b0;
         in_ready  <= 1'b1;
         out_valid <= 1'b0;
         busy      <= 1'b0;
`ifdef SERIAL_ADDER_OVF_EN
         ovf       <= 1'b0;
`endif
      end else begin
         case (r_state)
            IDLE: begin
               if (in_valid) begin
                  r_a      <= a;
                  r_b      <= b;
                  r_carry  <= cin;
                  r_cnt    <= '0;
                  r_state  <= RUN;
                  in_ready <= 1'b0;
                  busy     <= 1'b1;
               end
            end
            RUN: begin
               r_a     <= r_a >> SLICE;
               r_b     <= r_b >> SLICE;
               r_acc   <= w_acc_next;
               r_carry <= w_co;
               r_cnt   <= r_cnt + CW'(1);
               if (r_cnt == LAST) begin
                  r_state   <= DONE;
                  sum       <= w_acc_next;
                  cout      <= w_co;
                  out_valid <= 1'b1;
`ifdef SERIAL_ADDER_OVF_EN
                  ovf       <= w_ovf;
`endif
               end
            end
            DONE: begin
               if (out_ready) begin
                  r_state   <= IDLE;
                  out_valid <= 1'b0;
                  busy      <= 1'b0;
                  in_ready  <= 1'b1;
               end
            end
            default: begin
               r_state   <= IDLE;
               out_valid <= 1'b0;
               busy      <= 1'b0;
               in_ready  <= 1'b1;
            end
         endcase
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_serial_adder.sv
`default_nettype none
// ============================================================================
// Module  : tb_serial_adder
// Brief   : Scoreboard bench for serial_adder (SLICE=1 and SLICE=2 instances).
//           Optional macro SERIAL_ADDER_OVF_EN enables the overflow checks.
// Rev     : 1.0  initial release
// ============================================================================
module tb_serial_adder;

   typedef struct packed {
      logic [7:0] s;
      logic       co;
      logic       ov;
   } exp_t;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   logic rst_n;
   logic iv1, ir1, ci1, ov1, or1, co1, bz1;
   logic [7:0] a1, b1, s1;
   logic iv2, ir2, ci2, ov2, or2, co2, bz2;
   logic [7:0] a2, b2, s2;
`ifdef SERIAL_ADDER_OVF_EN
   logic ovf1, ovf2;
`endif

   int n_vec  = 0;
   int n_fail = 0;
   exp_t q1[$];
   exp_t q2[$];
   exp_t m1, m2;

   serial_adder #(.WIDTH(8), .SLICE(1)) u_dut1 (
      .clk(clk), .rst_n(rst_n), .in_valid(iv1), .in_ready(ir1), .a(a1), .b(b1),
      .cin(ci1), .out_valid(ov1), .out_ready(or1), .sum(s1), .cout(co1), .busy(bz1)
`ifdef SERIAL_ADDER_OVF_EN
      , .ovf(ovf1)
`endif
   );

   serial_adder #(.WIDTH(8), .SLICE(2)) u_dut2 (
      .clk(clk), .rst_n(rst_n), .in_valid(iv2), .in_ready(ir2), .a(a2), .b(b2),
      .cin(ci2), .out_valid(ov2), .out_ready(or2), .sum(s2), .cout(co2), .busy(bz2)
`ifdef SERIAL_ADDER_OVF_EN
      , .ovf(ovf2)
`endif
   );

   task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, act, exp, cyc);
      end
   endtask

   // Reference: full 9-bit sum, and carry into bit 7 from a 7-bit partial add
   function automatic exp_t model(input logic [7:0] x, input logic [7:0] y, input logic c);
      logic [8:0] full;
      logic [7:0] low;
      exp_t e;
      full = {1'b0, x} + {1'b0, y} + {8'd0, c};
      low  = {1'b0, x[6:0]} + {1'b0, y[6:0]} + {7'd0, c};
      e.s  = full[7:0];
      e.co = full[8];
      e.ov = low[7] ^ full[8];
      return e;
   endfunction

   // Result monitors: compare whenever a result is handed over
   always @(negedge clk) begin
      if (rst_n && ov1 && or1) begin
         if (q1.size() == 0) chk("spurious_out1", 1, 0);
         else begin
            m1 = q1.pop_front();
            chk("sum1", {24'd0, s1}, {24'd0, m1.s});
            chk("cout1", {31'd0, co1}, {31'd0, m1.co});
`ifdef SERIAL_ADDER_OVF_EN
            chk("ovf1", {31'd0, ovf1}, {31'd0, m1.ov});
`endif
         end
      end
   end

   always @(negedge clk) begin
      if (rst_n && ov2 && or2) begin
         if (q2.size() == 0) chk("spurious_out2", 1, 0);
         else begin
            m2 = q2.pop_front();
            chk("sum2", {24'd0, s2}, {24'd0, m2.s});
            chk("cout2", {31'd0, co2}, {31'd0, m2.co});
`ifdef SERIAL_ADDER_OVF_EN
            chk("ovf2", {31'd0, ovf2}, {31'd0, m2.ov});
`endif
         end
      end
   end

   // Offer operands; returns just after the accepting edge with its cycle number
   task automatic send(input int which, input logic [7:0] x, input logic [7:0] y,
                       input logic c, output int t_acc);
      bit ok;
      ok = 1'b0;
      if (which == 1) begin a1 = x; b1 = y; ci1 = c; iv1 = 1'b1; end
      else            begin a2 = x; b2 = y; ci2 = c; iv2 = 1'b1; end
      for (int i = 0; i < 50; i++) begin
         @(negedge clk);
         if ((which == 1) ? ir1 : ir2) begin ok = 1'b1; break; end
      end
      if (!ok) chk("accept_timeout", 0, 1);
      else if (which == 1) q1.push_back(model(x, y, c));
      else q2.push_back(model(x, y, c));
      @(posedge clk);
      #1;
      t_acc = cyc;
      if (which == 1) iv1 = 1'b0; else iv2 = 1'b0;
   endtask

   // Wait for out_valid and check latency from the accepting edge
   task automatic wait_out(input int which, input int t_acc, input int lat);
      bit seen;
      seen = 1'b0;
      for (int k = 1; k <= 40; k++) begin
         @(posedge clk);
         #1;
         if (k == 1) begin
            chk("busy_run", {31'd0, (which == 1) ? bz1 : bz2}, 1);
            chk("in_ready_run", {31'd0, (which == 1) ? ir1 : ir2}, 0);
         end
         if ((which == 1) ? ov1 : ov2) begin seen = 1'b1; break; end
      end
      if (!seen) chk("out_valid_timeout", 0, 1);
      else chk("latency", cyc - t_acc, lat);
   endtask

   initial begin
      int t0, tprev;
      bit seen;
      exp_t e;
      rst_n = 1'b0;
      iv1 = 0; a1 = 0; b1 = 0; ci1 = 0; or1 = 1;
      iv2 = 0; a2 = 0; b2 = 0; ci2 = 0; or2 = 1;

      // Reset values
      @(posedge clk); #1;
      chk("rst_in_ready", {31'd0, ir1}, 1);
      chk("rst_out_valid", {31'd0, ov1}, 0);
      chk("rst_sum", {24'd0, s1}, 0);
      chk("rst_cout", {31'd0, co1}, 0);
      chk("rst_busy", {31'd0, bz1}, 0);
      @(negedge clk); rst_n = 1'b1;
      @(posedge clk); #1;

      // Basic add, SLICE=1: 0x35+0x4A -> 0x7F, 8-cycle latency
      send(1, 8'h35, 8'h4A, 1'b0, t0);
      wait_out(1, t0, 8);
      @(posedge clk); #1;

      // Reset during RUN: immediate clear, no result afterwards
      send(1, 8'h11, 8'h22, 1'b0, t0);
      repeat (3) @(posedge clk);
      #1;
      rst_n = 1'b0;
      #1;
      chk("abort_out_valid", {31'd0, ov1}, 0);
      chk("abort_sum", {24'd0, s1}, 0);
      chk("abort_cout", {31'd0, co1}, 0);
      chk("abort_busy", {31'd0, bz1}, 0);
      chk("abort_in_ready", {31'd0, ir1}, 1);
      q1.delete();
      @(negedge clk); rst_n = 1'b1;
      seen = 1'b0;
      repeat (12) begin
         @(posedge clk); #1;
         seen = seen | ov1;
      end
      chk("abort_no_result", {31'd0, seen}, 0);

      // Back-pressure in DONE: result held, new offers ignored
      or1 = 1'b0;
      send(1, 8'hA5, 8'h5B, 1'b1, t0);
      e = model(8'hA5, 8'h5B, 1'b1);
      wait_out(1, t0, 8);
      iv1 = 1'b1; a1 = 8'h0F; b1 = 8'h0F; ci1 = 1'b0;
      for (int i = 0; i < 5; i++) begin
         @(posedge clk); #1;
         chk("hold_out_valid", {31'd0, ov1}, 1);
         chk("hold_in_ready", {31'd0, ir1}, 0);
         chk("hold_sum", {24'd0, s1}, {24'd0, e.s});
         chk("hold_cout", {31'd0, co1}, {31'd0, e.co});
      end
      iv1 = 1'b0; or1 = 1'b1;
      @(posedge clk); #1;
      chk("release_out_valid", {31'd0, ov1}, 0);
      chk("release_in_ready", {31'd0, ir1}, 1);
      chk("release_busy", {31'd0, bz1}, 0);

      // Operands change during RUN: result uses captured values
      send(1, 8'h12, 8'h34, 1'b0, t0);
      a1 = 8'hFF; b1 = 8'hFF; ci1 = 1'b1;
      wait_out(1, t0, 8);
      @(posedge clk); #1;

      // Back-to-back random operations: one per N+2 cycles
      tprev = 0;
      for (int i = 0; i < 4; i++) begin
         send(1, 8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)),
              1'($urandom_range(0, 1)), t0);
         if (i > 0) chk("throughput", t0 - tprev, 10);
         tprev = t0;
      end
      repeat (12) @(posedge clk);
      #1;

      // SLICE=2: carry ripples across every slice
      send(2, 8'hFF, 8'h00, 1'b1, t0);
      wait_out(2, t0, 4);
      send(2, 8'h9C, 8'h63, 1'b0, t0);
      wait_out(2, t0, 4);
      repeat (3) @(posedge clk);
      #1;

`ifdef SERIAL_ADDER_OVF_EN
      // Signed overflow cases
      send(1, 8'h7F, 8'h01, 1'b0, t0);
      wait_out(1, t0, 8);
      send(1, 8'h80, 8'h80, 1'b0, t0);
      wait_out(1, t0, 8);
      repeat (3) @(posedge clk);
      #1;
`endif

      chk("q1_drained", q1.size(), 0);
      chk("q2_drained", q2.size(), 0);
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
      $fatal(1, "watchdog");
   end

endmodule
`default_nettype wire
